// File: rtl/mu0_sequencer.sv
// MU0 control-phase sequencer: FETCH/EXEC1/EXEC2 strobes, run/step/halt,
// conditional-skip tracking and a saturating retired-instruction counter.
module mu0_sequencer #(
   parameter int unsigned    COUNT_W = 16,
   parameter logic [3:0]     SKIP_OP = 4'h9
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               RUN,
   input  logic               STEP,
   input  logic               EXTRA,
   input  logic [15:0]        IR,
   input  logic               EQ,
   input  logic               MI,
   output logic               FETCH,
   output logic               EXEC1,
   output logic               EXEC2,
   output logic               skipstatus,
   output logic               HALTED,
   output logic               IDLE,
   output logic [COUNT_W-1:0] INSTR_COUNT
);

   localparam logic [4:0] S_IDLE  = 5'b00001;
   localparam logic [4:0] S_FETCH = 5'b00010;
   localparam logic [4:0] S_EXEC1 = 5'b00100;
   localparam logic [4:0] S_EXEC2 = 5'b01000;
   localparam logic [4:0] S_HALT  = 5'b10000;

   localparam logic [3:0] STP_OP  = 4'h7;

   logic [4:0]         state_q, state_d;
   logic               skip_q, skip_d;
   logic               pend_q, pend_d;
   logic               armed_q, armed_d;
   logic [COUNT_W-1:0] count_q, count_d;

   logic               is_skc, is_stp, cond, retire, set_pend, pend_eff;

   assign is_skc   = (IR[15:12] == SKIP_OP);
   assign is_stp   = (IR[15:12] == STP_OP);
   assign cond     = IR[0] ? MI : EQ;
   assign retire   = ((state_q == S_EXEC1) && !EXTRA) || (state_q == S_EXEC2);
   assign set_pend = (state_q == S_EXEC1) && is_skc && !skip_q && cond;
   // An SKC retiring straight into FETCH must skip that very next instruction.
   assign pend_eff = pend_q | set_pend;

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      pend_d  = pend_eff;
      armed_d = armed_q;
      count_d = count_q;

      case (state_q)
         S_IDLE: begin
            if (RUN || STEP) state_d = S_FETCH;
            if (STEP)        armed_d = 1'b1;
         end
         S_FETCH: state_d = S_EXEC1;
         S_EXEC1: if (EXTRA) state_d = S_EXEC2;
         S_EXEC2: state_d = S_EXEC2;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      if (retire) begin
         skip_d = 1'b0;
         if (count_q != '1) count_d = count_q + 1'b1;
         if (is_stp && !skip_q) begin
            state_d = S_HALT;
         end else if (RUN && !armed_q) begin
            state_d = S_FETCH;
         end else begin
            state_d = S_IDLE;
            armed_d = 1'b0;
         end
      end

      if ((state_d == S_FETCH) && (state_q != S_FETCH) && pend_eff) begin
         skip_d = 1'b1;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         skip_q  <= 1'b0;
         pend_q  <= 1'b0;
         armed_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         pend_q  <= pend_d;
         armed_q <= armed_d;
         count_q <= count_d;
      end
   end

   assign IDLE        = state_q[0];
   assign FETCH       = state_q[1];
   assign EXEC1       = state_q[2];
   assign EXEC2       = state_q[3];
   assign HALTED      = state_q[4];
   assign skipstatus  = skip_q;
   assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Directed bench for mu0_sequencer: cycle table plus step, saturation and reset sequences.
module tb_mu0_sequencer;

   localparam logic [4:0] XI  = 5'b00001;
   localparam logic [4:0] XF  = 5'b00010;
   localparam logic [4:0] XE1 = 5'b00100;
   localparam logic [4:0] XE2 = 5'b01000;
   localparam logic [4:0] XH  = 5'b10000;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        RUN, STEP, EQ, MI, xtra;
   logic [15:0] IR;

   logic        EXTRA, FETCH, EXEC1, EXEC2, skipstatus, HALTED, IDLE;
   logic [15:0] INSTR_COUNT;
   logic        EXTRA4, FETCH4, EXEC1_4, EXEC2_4, skip4, HALTED4, IDLE4;
   logic [3:0]  COUNT4;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 CLK = ~CLK;

   // decoder model: requests EXEC2 only while the sequencer is in EXEC1
   assign EXTRA  = xtra & EXEC1;
   assign EXTRA4 = xtra & EXEC1_4;

   mu0_sequencer dut (
      .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP), .EXTRA(EXTRA),
      .IR(IR), .EQ(EQ), .MI(MI), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2),
      .skipstatus(skipstatus), .HALTED(HALTED), .IDLE(IDLE), .INSTR_COUNT(INSTR_COUNT)
   );

   mu0_sequencer #(.COUNT_W(4)) dut4 (
      .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP), .EXTRA(EXTRA4),
      .IR(IR), .EQ(EQ), .MI(MI), .FETCH(FETCH4), .EXEC1(EXEC1_4), .EXEC2(EXEC2_4),
      .skipstatus(skip4), .HALTED(HALTED4), .IDLE(IDLE4), .INSTR_COUNT(COUNT4)
   );

   typedef struct {
      logic        run, step, eq, mi, xt;
      logic [15:0] ir;
      logic [4:0]  st;
      logic        sk;
      int unsigned cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic run, logic step, logic [15:0] ir, logic eq,
                              logic mi, logic xt, logic [4:0] st, logic sk,
                              int unsigned cnt);
      vec_t r;
      r.run = run; r.step = step; r.ir = ir; r.eq = eq; r.mi = mi; r.xt = xt;
      r.st = st; r.sk = sk; r.cnt = cnt;
      return r;
   endfunction

   task automatic cmp(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk(input string name, input logic [4:0] st, input logic sk,
                      input int unsigned cnt);
      int unsigned sat;
      sat = (cnt > 15) ? 15 : cnt;
      cmp({name, "/state"}, {HALTED, EXEC2, EXEC1, FETCH, IDLE}, st);
      cmp({name, "/skip"}, skipstatus, sk);
      cmp({name, "/count"}, INSTR_COUNT, cnt);
      cmp({name, "/state4"}, {HALTED4, EXEC2_4, EXEC1_4, FETCH4, IDLE4}, st);
      cmp({name, "/count4"}, COUNT4, sat);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET_N = 1'b0; RUN = 1'b0; STEP = 1'b0; EQ = 1'b0; MI = 1'b0; xtra = 1'b0;
      IR = 16'h0000;

      tbl.push_back(v(1,0,16'h8005,0,0,0, XF, 0, 0));
      tbl.push_back(v(1,0,16'h8005,0,0,0, XE1,0, 0));
      tbl.push_back(v(1,0,16'h8005,0,0,0, XF, 0, 1));
      tbl.push_back(v(1,0,16'h8005,0,0,0, XE1,0, 1));
      tbl.push_back(v(1,0,16'h8005,0,0,0, XF, 0, 2));
      tbl.push_back(v(1,0,16'h8005,0,0,0, XE1,0, 2));
      tbl.push_back(v(1,0,16'h8005,0,0,0, XF, 0, 3));
      tbl.push_back(v(1,0,16'h0010,0,0,1, XE1,0, 3));
      tbl.push_back(v(1,0,16'h0010,0,0,1, XE2,0, 3));
      tbl.push_back(v(1,0,16'h0010,0,0,1, XF, 0, 4));
      tbl.push_back(v(1,0,16'h0010,0,0,1, XE1,0, 4));
      tbl.push_back(v(1,0,16'h0010,0,0,1, XE2,0, 4));
      tbl.push_back(v(1,0,16'h0010,0,0,1, XF, 0, 5));
      tbl.push_back(v(1,0,16'h9000,1,0,0, XE1,0, 5));
      tbl.push_back(v(1,0,16'h9000,1,0,0, XF, 1, 6));
      tbl.push_back(v(1,0,16'h4020,1,0,0, XE1,1, 6));
      tbl.push_back(v(1,0,16'h4020,1,0,0, XF, 0, 7));
      tbl.push_back(v(1,0,16'h9000,0,0,0, XE1,0, 7));
      tbl.push_back(v(1,0,16'h9000,0,0,0, XF, 0, 8));
      tbl.push_back(v(1,0,16'h4020,0,0,0, XE1,0, 8));
      tbl.push_back(v(1,0,16'h4020,0,0,0, XF, 0, 9));
      tbl.push_back(v(1,0,16'h9001,0,1,0, XE1,0, 9));
      tbl.push_back(v(1,0,16'h9001,0,1,0, XF, 1, 10));
      tbl.push_back(v(1,0,16'h7000,0,1,0, XE1,1, 10));
      tbl.push_back(v(1,0,16'h7000,0,1,0, XF, 0, 11));
      tbl.push_back(v(1,0,16'h9000,1,0,0, XE1,0, 11));
      tbl.push_back(v(1,0,16'h9000,1,0,0, XF, 1, 12));
      tbl.push_back(v(1,0,16'h9000,1,0,0, XE1,1, 12));
      tbl.push_back(v(1,0,16'h9000,1,0,0, XF, 0, 13));
      tbl.push_back(v(1,0,16'h7000,1,0,0, XE1,0, 13));
      tbl.push_back(v(1,0,16'h7000,1,0,0, XH, 0, 14));
      tbl.push_back(v(1,1,16'h7000,1,0,0, XH, 0, 14));
      tbl.push_back(v(0,1,16'h7000,1,0,0, XH, 0, 14));

      repeat (2) @(negedge CLK);
      chk("reset", XI, 0, 0);
      RESET_N = 1'b1;
      @(negedge CLK);
      chk("post_reset", XI, 0, 0);

      foreach (tbl[i]) begin
         RUN = tbl[i].run; STEP = tbl[i].step; IR = tbl[i].ir;
         EQ = tbl[i].eq; MI = tbl[i].mi; xtra = tbl[i].xt;
         tick();
         chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].sk, tbl[i].cnt);
      end

      RESET_N = 1'b0; RUN = 1'b0; STEP = 1'b0;
      #1;
      chk("halt_reset", XI, 0, 0);
      @(negedge CLK);
      RESET_N = 1'b1;

      // single-step an LDA; a STEP during EXEC1 must not queue
      IR = 16'h0010; xtra = 1'b1; EQ = 1'b0; MI = 1'b0; STEP = 1'b1;
      tick(); chk("step_f", XF, 0, 0);
      STEP = 1'b0;
      tick(); chk("step_e1", XE1, 0, 0);
      STEP = 1'b1;
      tick(); chk("step_e2", XE2, 0, 0);
      STEP = 1'b0;
      tick(); chk("step_idle", XI, 0, 1);
      tick(); chk("step_hold", XI, 0, 1);

      // skip pending across IDLE
      IR = 16'h9000; EQ = 1'b1; xtra = 1'b0; STEP = 1'b1;
      tick(); chk("skc_f", XF, 0, 1);
      STEP = 1'b0;
      tick(); chk("skc_e1", XE1, 0, 1);
      tick(); chk("skc_idle", XI, 0, 2);
      tick(); chk("skc_hold", XI, 0, 2);
      IR = 16'h4020; STEP = 1'b1;
      tick(); chk("jmp_f", XF, 1, 2);
      STEP = 1'b0;
      tick(); chk("jmp_e1", XE1, 1, 2);
      tick(); chk("jmp_idle", XI, 0, 3);

      // free-run LDI for 50 cycles: 24 retires
      IR = 16'h8005; RUN = 1'b1;
      repeat (50) tick();
      chk("sat", XE1, 0, 27);

      // reset in the middle of EXEC2
      IR = 16'h0010; xtra = 1'b1;
      begin
         int unsigned k;
         k = 0;
         while (!EXEC2 && k < 10) begin
            tick();
            k++;
         end
         cmp("reach_exec2", EXEC2, 1);
      end
      RESET_N = 1'b0;
      #1;
      chk("exec2_reset", XI, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
